rv_muldiv: RTL and testbench

Iterative multiply/divide unit for the RV32M extension, parametrised in operand width. It sits in the execute stage beside the single-cycle ALU and handles every M-extension operation under a valid/ready handshake. Operands are processed one bit per cycle with a shared adder. Divide-by-zero and signed overflow are detected up front and answered without iterating.

---
 rtl/rv_muldiv_if.sv | 26 ++
 rtl/rv_muldiv.sv | 174 +++++++++++++++++
 tb/tb_rv_muldiv.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rv_muldiv_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The requester drives the master side and the unit implements the slave side.
interface rv_muldiv_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_src_a;
  logic [XLEN-1:0] i_src_b;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport slave (
    input  i_valid, i_op, i_src_a, i_src_b, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );

  modport master (
    output i_valid, i_op, i_src_a, i_src_b, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// both sharing a single XLEN+1-bit adder. Divide-by-zero and signed overflow skip the iterations.
module rv_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input logic          i_clk,
  input logic          i_reset,
  rv_muldiv_if.slave   bus_io
);
  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q, neg_d;
  logic            fin_q, fin_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            accept;
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   add_a, add_b;
  logic            add_cin;
  logic [XLEN+1:0] add_sum;
  logic            ge;
  logic [XLEN-1:0] hi_step, lo_step;
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0] quot_f, rem_f, result_fin;

  assign bus_io.o_ready  = (state_q == StIdle) || ((state_q == StDone) && bus_io.i_ready);
  assign bus_io.o_valid  = (state_q == StDone);
  assign bus_io.o_busy   = (state_q != StIdle);
  assign bus_io.o_result = result_q;

  assign accept = bus_io.i_valid && bus_io.o_ready && !bus_io.i_flush;

  // Operand decode for the incoming request.
  always_comb begin
    is_div = bus_io.i_op[2];
    a_sgn  = (bus_io.i_op == 3'd1) || (bus_io.i_op == 3'd2) ||
             (bus_io.i_op == 3'd4) || (bus_io.i_op == 3'd6);
    b_sgn  = (bus_io.i_op == 3'd1) || (bus_io.i_op == 3'd4) || (bus_io.i_op == 3'd6);
    a_neg  = a_sgn && bus_io.i_src_a[XLEN-1];
    b_neg  = b_sgn && bus_io.i_src_b[XLEN-1];
    a_abs  = a_neg ? -bus_io.i_src_a : bus_io.i_src_a;
    b_abs  = b_neg ? -bus_io.i_src_b : bus_io.i_src_b;
    b_zero = (bus_io.i_src_b == '0);
    ovf    = bus_io.i_op[2] && !bus_io.i_op[0] && (bus_io.i_src_a == MinVal) &&
             (&bus_io.i_src_b);
  end

  // Shared adder: accumulate for multiply, trial-subtract (carry out = no borrow) for divide.
  always_comb begin
    if (op_q[2]) begin
      add_a   = {hi_q, lo_q[XLEN-1]};
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, opnd_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_cin};
    ge      = add_sum[XLEN+1];
    if (op_q[2]) begin
      hi_step = ge ? add_sum[XLEN-1:0] : add_a[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_step = add_sum[XLEN:1];
      lo_step = {add_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_f = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_f = neg_q ? -lo_q : lo_q;
    rem_f  = neg_q ? -hi_q : hi_q;
    case (op_q)
      3'd0:                result_fin = prod_f[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    result_fin = prod_f[2*XLEN-1:XLEN];
      3'd4, 3'd5:          result_fin = quot_f;
      default:             result_fin = rem_f;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    fin_d    = fin_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: if (fin_q) state_d = StDone;
      StDone: begin
        if (accept)                 state_d = StCalc;
        else if (bus_io.i_ready)    state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      op_d  = bus_io.i_op;
      cnt_d = CntW'(XLEN - 1);
      fin_d = 1'b0;
      hi_d  = '0;
      neg_d = (is_div && bus_io.i_op[1]) ? a_neg : (a_neg ^ b_neg);
      if (is_div) begin
        opnd_d = b_abs;
        lo_d   = a_abs;
        // Special cases preload the final quotient/remainder and finish after one cycle.
        if (b_zero) begin
          fin_d = 1'b1;
          neg_d = 1'b0;
          lo_d  = '1;
          hi_d  = bus_io.i_src_a;
        end else if (ovf) begin
          fin_d = 1'b1;
          neg_d = 1'b0;
          lo_d  = MinVal;
        end
      end else begin
        opnd_d = a_abs;
        lo_d   = b_abs;
      end
    end else if ((state_q == StCalc) && !bus_io.i_flush) begin
      if (fin_q) begin
        result_d = result_fin;
      end else begin
        hi_d = hi_step;
        lo_d = lo_step;
        if (cnt_q == '0) fin_d = 1'b1;
        else             cnt_d = cnt_q - CntW'(1);
      end
    end

    if (bus_io.i_flush) state_d = StIdle;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      fin_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      fin_q    <= fin_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_rv_muldiv.sv
// Directed bench for rv_muldiv (XLEN=32): results, latency, backpressure, flush and reset.
module tb_rv_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  rv_muldiv_if #(.XLEN(32)) bus ();

  rv_muldiv #(.XLEN(32)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus_io  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the edge that accepts it.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int waited;
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_src_a = a;
    bus.i_src_b = b;
    waited = 0;
    while (!bus.o_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) chk("send_ready_timeout", 32'(waited), 32'd0);
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!bus.o_valid && cycles < 100);
    if (!bus.o_valid) chk("result_timeout", 32'(bus.o_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    send(op, a, b);
    wait_result(cyc);
    chk(tag, bus.o_result, exp);
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int vhigh;
    bus.i_valid = 1'b0;
    bus.i_op    = '0;
    bus.i_src_a = '0;
    bus.i_src_b = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_result", bus.o_result, 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);

    run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'd5, 32'd100,      32'd7,        32'h0000000E, 33);
    run_op("remu",   3'd7, 32'd100,      32'd7,        32'h00000002, 33);

    run_op("div_by0",  3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_by0",  3'd6, 32'd5,        32'd0,        32'h00000005, 1);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Backpressure in DONE, then handshake and new accept in the same cycle.
    send(3'd5, 32'd100, 32'd7);
    wait_result(cyc);
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", bus.o_result, 32'h0000000E);
      chk("bp_ready", 32'(bus.o_ready), 32'd0);
      chk("bp_valid", 32'(bus.o_valid), 32'd1);
      tick();
    end
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_op    = 3'd7;
    bus.i_src_a = 32'd100;
    bus.i_src_b = 32'd7;
    #1;
    chk("b2b_ready", 32'(bus.o_ready), 32'd1);
    tick();
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    chk("b2b_valid_drop", 32'(bus.o_valid), 32'd0);
    chk("b2b_busy", 32'(bus.o_busy), 32'd1);
    wait_result(cyc);
    chk("b2b_result", bus.o_result, 32'h00000002);
    chk("b2b_lat", 32'(cyc), 32'd33);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;

    // Flush asserted in the cycle after edge T+10.
    send(3'd0, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) tick();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("flush_ready", 32'(bus.o_ready), 32'd1);
    chk("flush_busy", 32'(bus.o_busy), 32'd0);
    vhigh = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_valid) vhigh++;
      tick();
    end
    chk("flush_no_valid", 32'(vhigh), 32'd0);

    // Reset mid-CALC clears outputs; the next request completes normally.
    send(3'd3, 32'hFFFFFFFF, 32'd2);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    chk("midrst_result", bus.o_result, 32'd0);
    chk("midrst_busy", 32'(bus.o_busy), 32'd0);
    chk("midrst_ready", 32'(bus.o_ready), 32'd1);
    run_op("post_rst_div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "watchdog");
  end
endmodule
